sram_arbiter: RTL
=================

Name: sram_arbiter

Overview:
- Shares one single-port synchronous SRAM (1-cycle read latency, active-low cen/wen/ben) among three requesters: the RV32E data port, a DMA/pixel loader, and RV32E instruction fetch.
- Core data accesses are never stalled.
- Instruction fetch is throttled through inst_ready.
- DMA uses a req/gnt handshake with a registered read return.
- A fetch-starvation counter bounds how long DMA can lock out fetch.

Parameters:
- AW, 32, address width for all ports.
- FETCH_WAIT_MAX, 4, consecutive fetch denials caused by DMA before fetch outranks DMA.
- WCNT_W, $clog2(FETCH_WAIT_MAX+1), width of the wait counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- f_req  in  1  fetch request (core drives high out of reset)
- inst_addr  in  AW  fetch word address (core pc_next)
- instruction  out  32  fetched word
- inst_ready  out  1  instruction valid this cycle
- d_cen  in  1  core data access, active low
- d_wen  in  1  core write enable, active low
- d_ben  in  4  core byte enables, active low
- d_addr  in  AW  core data address
- d_din  in  32  core write data
- d_dout  out  32  core read data, valid the cycle after the access
- dma_req  in  1  DMA access request, held until granted
- dma_we  in  1  DMA write, active high
- dma_ben  in  4  DMA byte enables, active low
- dma_addr  in  AW  DMA address
- dma_wdata  in  32  DMA write data
- dma_gnt  out  1  DMA access issued this cycle
- dma_rvalid  out  1  dma_rdata valid (read only)
- dma_rdata  out  32  DMA read data
- sram_cen, sram_wen  out  1  SRAM chip and write enable, active low
- sram_ben  out  4  SRAM byte enables, active low
- sram_addr  out  AW  SRAM address
- sram_din  out  32  SRAM write data
- sram_dout  in  32  SRAM read data, valid one cycle after issue

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n; all registers are cleared on the clk edge while rst_n=0.
- Grant (combinational, same cycle):
  - Candidates are data (!d_cen), DMA (dma_req) and fetch (f_req).
  - Base priority is data > DMA > fetch.
  - If wait_cnt==FETCH_WAIT_MAX, fetch outranks DMA. Data always wins.
  - With no requester: sram_cen=1, sram_wen=1, sram_ben=4'hF.
- SRAM mux:
  - The granted source drives addr, din, ben and wen. DMA wen is !dma_we. Fetch forces wen=1 and ben=4'h0.
  - sram_cen=0 whenever any grant exists.
- dma_gnt=1 exactly in the cycle DMA is issued; the requester may change its request fields the next cycle.
- Owner register (typedef owner_t: OWN_NONE, OWN_DATA, OWN_DMA, OWN_FETCH; reset OWN_NONE):
  - Captures the granted source each cycle.
  - A write records OWN_NONE, except a DMA write, which records OWN_NONE and produces no rvalid.
- Return path (cycle N+1 after issue at N):
  - inst_ready = (owner==OWN_FETCH); instruction = sram_dout. When not ready, instruction = 32'h00000013 (NOP constant).
  - d_dout = sram_dout, unconditionally; the core only samples it after its own access.
  - dma_rvalid = (owner==OWN_DMA); dma_rdata = sram_dout.
- wait_cnt:
  - Increments, saturating at FETCH_WAIT_MAX, when f_req=1 and DMA is granted.
  - Clears when fetch is granted or f_req=0.
  - Holds when data wins.
- Latency:
  - Data: 0 wait states.
  - DMA and fetch: 1-cycle read return after grant.
  - Fetch worst case with continuous DMA: FETCH_WAIT_MAX denials, then a grant.
- Reset:
  - During reset: sram_cen=1, inst_ready=0, dma_gnt=0, dma_rvalid=0, owner=OWN_NONE, wait_cnt=0.
  - A read in flight when reset is applied is dropped; no rvalid or inst_ready follows it.
- Simultaneous events:
  - If data and a saturated fetch collide, data wins and wait_cnt stays saturated. Fetch is granted the next cycle in which data is idle.
  - If dma_req deasserts without a grant (protocol violation), nothing is issued.

Decomposition:
- Shared package (types): owner_t, NOP (already used by the core), and the grant encoding grant_t {GNT_NONE, GNT_DATA, GNT_DMA, GNT_FETCH}.
- One natural sub-module: sram_prio_sel. It is combinational: it takes the three requests plus the starve flag and returns grant_t. Counter, owner register and muxes stay in sram_arbiter.

Test Plan:
- Fetch only: f_req=1, inst_addr=0x100 then 0x104 -> sram_addr 0x100 then 0x104. inst_ready=1 from the second cycle, with instruction equal to SRAM contents.
- Data vs fetch: d_cen=0, d_wen=0, d_addr=0x2000, d_din=0xDEADBEEF, f_req=1 -> SRAM writes 0x2000 and inst_ready=0 the next cycle. On the following cycle fetch is granted; a later core read of 0x2000 returns 0xDEADBEEF on d_dout.
- DMA starvation bound: dma_req held high for 10 cycles, f_req=1, FETCH_WAIT_MAX=4.
  - dma_gnt=1 for 4 cycles, then one fetch grant, then DMA again.
  - No more than 4 consecutive dma_gnt while a fetch is pending.
- DMA read: dma_req=1, dma_we=0, dma_addr=0x3000 (SRAM contents 0x12345678) -> dma_gnt in cycle N; dma_rvalid=1 and dma_rdata=0x12345678 in N+1. A DMA write produces no rvalid.
- Three-way collision: data + DMA + saturated fetch in the same cycle -> data granted. The next idle-data cycle grants fetch over DMA, and wait_cnt clears.
- Reset mid-read: fetch issued at cycle N, rst_n=0 at N+1 -> inst_ready=0 and sram_cen=1 during reset. After release the first grant is fetch, with inst_ready one cycle later.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared types for the single-port SRAM arbiter: grant encoding, read-return
// ownership and the RV32 NOP the core already uses.
package sram_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_DATA,
        OWN_DMA,
        OWN_FETCH
    } owner_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_DATA,
        GNT_DMA,
        GNT_FETCH
    } grant_t;

    localparam logic [31:0] NOP = 32'h00000013;

endpackage

// File: rtl/sram_prio_sel.sv
// Combinational priority select: data > DMA > fetch, with a starved fetch
// promoted above DMA. Data is never outranked.
module sram_prio_sel
    import sram_arbiter_pkg::*;
(
    input  logic   data_req_i,
    input  logic   dma_req_i,
    input  logic   fetch_req_i,
    input  logic   starve_i,
    output grant_t grant_o
);

    always_comb begin
        grant_o = GNT_NONE;
        if (data_req_i) begin
            grant_o = GNT_DATA;
        end else if (fetch_req_i && starve_i) begin
            grant_o = GNT_FETCH;
        end else if (dma_req_i) begin
            grant_o = GNT_DMA;
        end else if (fetch_req_i) begin
            grant_o = GNT_FETCH;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port synchronous SRAM among core data, DMA and fetch;
// tracks the owner of each read so the return lands on the right port.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int AW             = 32,
    parameter int FETCH_WAIT_MAX = 4,
    parameter int WCNT_W         = $clog2(FETCH_WAIT_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          f_req,
    input  logic [AW-1:0] inst_addr,
    output logic [31:0]   instruction,
    output logic          inst_ready,
    input  logic          d_cen,
    input  logic          d_wen,
    input  logic [3:0]    d_ben,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_din,
    output logic [31:0]   d_dout,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [3:0]    dma_ben,
    input  logic [AW-1:0] dma_addr,
    input  logic [31:0]   dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [31:0]   dma_rdata,
    output logic          sram_cen,
    output logic          sram_wen,
    output logic [3:0]    sram_ben,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_din,
    input  logic [31:0]   sram_dout
);

    grant_t              gnt;
    owner_t              owner_q, owner_d;
    logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                starve;

    assign starve = (wait_cnt_q == WCNT_W'(FETCH_WAIT_MAX));

    // Requests are masked in reset so the SRAM stays deselected.
    sram_prio_sel u_prio_sel (
        .data_req_i  (rst_n & ~d_cen),
        .dma_req_i   (rst_n & dma_req),
        .fetch_req_i (rst_n & f_req),
        .starve_i    (starve),
        .grant_o     (gnt)
    );

    always_comb begin
        sram_cen  = 1'b1;
        sram_wen  = 1'b1;
        sram_ben  = 4'hF;
        sram_addr = '0;
        sram_din  = '0;
        unique case (gnt)
            GNT_DATA: begin
                sram_cen  = 1'b0;
                sram_wen  = d_wen;
                sram_ben  = d_ben;
                sram_addr = d_addr;
                sram_din  = d_din;
            end
            GNT_DMA: begin
                sram_cen  = 1'b0;
                sram_wen  = ~dma_we;
                sram_ben  = dma_ben;
                sram_addr = dma_addr;
                sram_din  = dma_wdata;
            end
            GNT_FETCH: begin
                sram_cen  = 1'b0;
                sram_wen  = 1'b1;
                sram_ben  = 4'h0;
                sram_addr = inst_addr;
            end
            default: ;
        endcase
    end

    assign dma_gnt = (gnt == GNT_DMA);

    // Only reads own the next-cycle return; writes leave the owner empty.
    always_comb begin
        owner_d = OWN_NONE;
        unique case (gnt)
            GNT_DATA:  owner_d = d_wen  ? OWN_DATA : OWN_NONE;
            GNT_DMA:   owner_d = dma_we ? OWN_NONE : OWN_DMA;
            GNT_FETCH: owner_d = OWN_FETCH;
            default:   owner_d = OWN_NONE;
        endcase
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!f_req || gnt == GNT_FETCH) begin
            wait_cnt_d = '0;
        end else if (gnt == GNT_DMA && !starve) begin
            wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q    <= OWN_NONE;
            wait_cnt_q <= '0;
        end else begin
            owner_q    <= owner_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Returns are gated by rst_n so a read in flight at reset is dropped.
    assign inst_ready  = rst_n && (owner_q == OWN_FETCH);
    assign instruction = inst_ready ? sram_dout : NOP;
    assign d_dout      = sram_dout;
    assign dma_rvalid  = rst_n && (owner_q == OWN_DMA);
    assign dma_rdata   = sram_dout;

endmodule
